// File: rtl/axis_width_pkg.sv
// axis_width_pkg: shared widths and state encoding for the 512/64 AXI-Stream width converters
package axis_width_pkg;
   localparam int C_S00_AXIS_TDATA_WIDTH = 512;
   localparam int C_M00_AXIS_TDATA_WIDTH = 64;
   localparam int NUM_OF_BEATS = C_S00_AXIS_TDATA_WIDTH / C_M00_AXIS_TDATA_WIDTH;
   localparam int LANE_W = $clog2(NUM_OF_BEATS);
   localparam int KEEP_PER_LANE = 8;
   localparam int S_KEEP_W = C_S00_AXIS_TDATA_WIDTH / 8;
   localparam int M_KEEP_W = C_M00_AXIS_TDATA_WIDTH / 8;
   typedef enum logic {EMPTY, SERIALIZE} state_t;
endpackage

// File: rtl/axis_keep_last_lane.sv
// axis_keep_last_lane: index of the highest lane with any TKEEP bit set, plus an all-zero flag
module axis_keep_last_lane
   import axis_width_pkg::*;
(
   input  logic [S_KEEP_W-1:0] tkeep,
   output logic [LANE_W-1:0]   last_lane,
   output logic                all_zero
);
   always_comb begin
      last_lane = '0;
      all_zero = 1'b1;
      for (int i = 0; i < NUM_OF_BEATS; i++)
         if (|tkeep[i*KEEP_PER_LANE +: KEEP_PER_LANE]) begin
            last_lane = LANE_W'(i);
            all_zero = 1'b0;
         end
   end
endmodule

// File: rtl/axis_downsizer_512_to_64.sv
// axis_downsizer_512_to_64: serialises 512-bit AXI-Stream beats into 64-bit lanes, LSB lane first,
// trimming trailing empty lanes by TKEEP and preserving TLAST.
module axis_downsizer_512_to_64
   import axis_width_pkg::*;
(
   input  logic                              aclk,
   input  logic                              aresetn,
   input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
   input  logic [S_KEEP_W-1:0]               S_AXIS_TKEEP,
   input  logic                              S_AXIS_TVALID,
   input  logic                              S_AXIS_TLAST,
   output logic                              S_AXIS_TREADY,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
   output logic [M_KEEP_W-1:0]               M_AXIS_TKEEP,
   output logic                              M_AXIS_TVALID,
   output logic                              M_AXIS_TLAST,
   input  logic                              M_AXIS_TREADY
);
   state_t state, state_d;
   logic [C_S00_AXIS_TDATA_WIDTH-1:0] data_q;
   logic [S_KEEP_W-1:0] keep_q;
   logic last_q;
   logic [LANE_W-1:0] lane, last_lane_q, enc_lane;
   logic enc_zero, in_hs, out_hs, beat_done, keep_beat;

   axis_keep_last_lane u_enc (.tkeep(S_AXIS_TKEEP), .last_lane(enc_lane), .all_zero(enc_zero));

   assign M_AXIS_TVALID = state == SERIALIZE;
   assign out_hs = M_AXIS_TVALID && M_AXIS_TREADY;
   assign beat_done = out_hs && lane == last_lane_q;
   // Accepting on the final lane handshake lets wide beats stream without a bubble.
   assign S_AXIS_TREADY = state == EMPTY || beat_done;
   assign in_hs = S_AXIS_TVALID && S_AXIS_TREADY;
   assign keep_beat = !enc_zero || S_AXIS_TLAST;
   assign M_AXIS_TDATA = data_q[lane*C_M00_AXIS_TDATA_WIDTH +: C_M00_AXIS_TDATA_WIDTH];
   assign M_AXIS_TKEEP = keep_q[lane*KEEP_PER_LANE +: KEEP_PER_LANE];
   assign M_AXIS_TLAST = M_AXIS_TVALID && last_q && lane == last_lane_q;

   always_comb begin
      state_d = state;
      state_d = in_hs ? (keep_beat ? SERIALIZE : EMPTY) : beat_done ? EMPTY : state;
   end

   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) state <= EMPTY;
      else state <= state_d;

   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
         data_q <= '0;
         keep_q <= '0;
         last_q <= 1'b0;
         last_lane_q <= '0;
         lane <= '0;
      end else begin
         if (in_hs && keep_beat) begin
            data_q <= S_AXIS_TDATA;
            keep_q <= S_AXIS_TKEEP;
            last_q <= S_AXIS_TLAST;
            last_lane_q <= enc_lane;
         end
         lane <= (in_hs || beat_done) ? '0 : out_hs ? lane + 1'b1 : lane;
      end
endmodule

// File: doc/axis_downsizer_512_to_64.md
# axis_downsizer_512_to_64

Serialises 512-bit AXI-Stream beats from the LDPC side into 64-bit beats toward the DMA side. It is the return-path partner of the 64-to-512 collector. Each wide beat is split into up to eight 64-bit lanes, LSB lane first. Trailing empty lanes are trimmed using TKEEP, and packet boundaries are preserved on TLAST.

## Interface
- C_S00_AXIS_TDATA_WIDTH, 512, wide input data width.
- C_M00_AXIS_TDATA_WIDTH, 64, narrow output data width.
- NUM_OF_BEATS, C_S00_AXIS_TDATA_WIDTH / C_M00_AXIS_TDATA_WIDTH (8), lanes per wide beat. Must be a power of two and at least 2.
- aclk  in  1  single clock; all logic on the rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- S_AXIS_TDATA  in  512  wide data; lane k is bits [64k+63:64k].
- S_AXIS_TKEEP  in  64  byte enables; lanes are packed from lane 0.
- S_AXIS_TVALID  in  1  input valid.
- S_AXIS_TLAST  in  1  end of packet.
- S_AXIS_TREADY  out  1  input ready.
- M_AXIS_TDATA  out  64  narrow data.
- M_AXIS_TKEEP  out  8  byte enables of the emitted lane.
- M_AXIS_TVALID  out  1  output valid.
- M_AXIS_TLAST  out  1  end of packet; only meaningful while M_AXIS_TVALID is high.
- M_AXIS_TREADY  in  1  output ready.

## Operation
- **States:**
  - EMPTY: the holding register is free.
  - SERIALIZE: the holding register holds one wide beat.
- **Capture.** On an input handshake, latch TDATA, TKEEP and TLAST into the holding register. Set lane = 0.
  - Set last_lane = index of the highest lane whose 8-bit TKEEP slice is nonzero.
- **Emission.** In SERIALIZE:
  - M_AXIS_TDATA = lane[lane] of the held data.
  - M_AXIS_TKEEP = the matching 8-bit TKEEP slice.
  - M_AXIS_TLAST = held TLAST && (lane == last_lane).
  - On an output handshake with lane < last_lane: increment lane.
  - On an output handshake with lane == last_lane: the beat is done.
- **S_AXIS_TREADY** = (state == EMPTY) || (M_AXIS_TVALID && M_AXIS_TREADY && lane == last_lane).
  - This is the only combinational input-to-output path. It allows back-to-back wide beats with no bubble.
- **End of beat with a new input handshake in the same cycle:** reload the holding register and stay in SERIALIZE.
- **End of beat with no input handshake:** go to EMPTY.
- **All-zero TKEEP with TLAST = 0:** the beat is accepted and dropped. No output, and the state stays EMPTY.
- **All-zero TKEEP with TLAST = 1:** emit one narrow beat with lane 0 data, TKEEP = 0x00, TLAST = 1.
- **Non-contiguous TKEEP (a hole below the highest set lane):**
  - Lanes up to last_lane are emitted as-is, including any all-zero lanes.
  - The block does not flag an error.
- **Lane counter:** log2(NUM_OF_BEATS) bits and never wraps past last_lane.
- **Stall stability:** while M_AXIS_TVALID = 1 and M_AXIS_TREADY = 0, all M_AXIS_* outputs hold stable.

## Timing
- **Reset values:** M_AXIS_TVALID = 0, M_AXIS_TLAST = 0, M_AXIS_TDATA = 0, M_AXIS_TKEEP = 0, state = EMPTY, lane = 0.
  - S_AXIS_TREADY = 1 one cycle after reset deassertion.
- **Latency:** a wide beat accepted at edge N presents lane 0 on M_AXIS_* after edge N; it is valid in cycle N+1.
- **Throughput:** one narrow beat per cycle while M_AXIS_TREADY = 1. A full beat takes exactly 8 cycles, and sustained full-TKEEP input gives 100% output utilisation.
- **Reset mid-operation:**
  - Assertion of aresetn = 0 immediately clears M_AXIS_TVALID and discards the held beat.
  - No partial packet resumes after reset.
- **M_AXIS_TREADY low:** the lane index holds and the input is not accepted. The outputs follow the stall-stability rule above.

## Structure
- **Package axis_width_pkg:**
  - localparams for both data widths, NUM_OF_BEATS and the lane index width;
  - the state enum (EMPTY, SERIALIZE);
  - KEEP_PER_LANE = 8.
- **Sub-module axis_keep_last_lane:** a combinational priority encoder from TKEEP (64 bits) to last_lane plus an all_zero flag. It is reused later by the collector for TKEEP generation.
- **Top:** the FSM, holding register, lane counter and output mux.

## Test plan
- **Single full beat:** data with lane k = 64'h1111_1111_1111_1111 × (k+1), TKEEP = all ones, TLAST = 1, M_AXIS_TREADY held 1.
  - Expect 8 beats, lane 0 through lane 7, TKEEP = 0xFF each.
  - TLAST only on the 8th beat; S_AXIS_TREADY low for the first 7 of those cycles.
- **Trimmed beat:** TKEEP = 64'h0000_0000_00FF_FFFF, TLAST = 1.
  - Expect 3 beats: TKEEP 0xFF, 0xFF, 0xFF; TLAST on the 3rd.
  - With TKEEP = 64'h0000_0000_000F_FFFF: the 3rd beat has TKEEP 0x0F.
- **Back-to-back:** two full beats A then B with S_AXIS_TVALID held high.
  - Expect 16 consecutive output cycles with no TVALID gap.
  - B is accepted in the same cycle that A lane 7 handshakes.
- **Backpressure:** M_AXIS_TREADY toggles 1,0,0,1 repeating.
  - Expect output data and TKEEP stable across stalls, no lane skipped or repeated, and all 8 lanes delivered in order.
- **Zero keep:** TKEEP = 0 with TLAST = 0 produces no output. TKEEP = 0 with TLAST = 1 produces exactly one beat with TKEEP = 0x00 and TLAST = 1.
- **Reset mid-beat:** assert aresetn = 0 after lane 3 is emitted.
  - M_AXIS_TVALID drops the same cycle.
  - After release, a new full beat emits from lane 0 with correct data.
